// File: rtl/imem_boot_loader.sv
// Boot loader: streams program words into instruction memory and holds
// the core in reset until the program is written and a settle period has passed.
module imem_boot_loader #(
    parameter  int DATA_W      = 32,
    parameter  int DEPTH       = 64,
    parameter  int HOLD_CYCLES = 4,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [DATA_W-1:0] imem_data_in,
    output logic              core_rst,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_done,
    output logic              load_err
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HCW-1:0]    r_hold;
    logic [HCW-1:0]    w_hold_nxt;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W:0]   w_words_nxt;
    logic              r_wr_en;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic              w_full;

    assign w_accept = load_valid && (r_state == S_LOAD);
    // The word about to be accepted occupies the final address
    assign w_full   = (r_words == (ADDR_W+1)'(DEPTH - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_words_nxt   = r_words;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        unique case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (load_start) begin
                    w_state_nxt = S_LOAD;
                    w_words_nxt = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_words[ADDR_W-1:0];
                    w_wr_data_nxt = load_data;
                    w_words_nxt   = r_words + (ADDR_W+1)'(1);
                    if (load_last) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = HCW'(HOLD_CYCLES);
                    end else if (w_full) begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                w_hold_nxt = r_hold - HCW'(1);
                if (r_hold == HCW'(1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_words    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_words    <= w_words_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_core_rst <= (w_state_nxt != S_RUN);
            r_done     <= (w_state_nxt == S_RUN);
            r_err      <= (w_state_nxt == S_ERR);
        end
    end

    assign load_ready   = (r_state == S_LOAD);
    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_data_in = r_wr_data;
    assign core_rst     = r_core_rst;
    assign words_loaded = r_words;
    assign load_done    = r_done;
    assign load_err     = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: DEPTH=64 and DEPTH=8 instances share one
// stimulus stream and are compared against a transaction-level model.
module tb_imem_boot_loader;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    logic        d64_ready, d64_wen, d64_crst, d64_done, d64_err;
    logic [5:0]  d64_addr;
    logic [31:0] d64_data;
    logic [6:0]  d64_wl;
    logic        d8_ready, d8_wen, d8_crst, d8_done, d8_err;
    logic [2:0]  d8_addr;
    logic [31:0] d8_data;
    logic [3:0]  d8_wl;

    imem_boot_loader #(.DATA_W(32), .DEPTH(64), .HOLD_CYCLES(HOLD)) u_d64 (
        .clk(clk), .rst(rst), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(d64_ready),
        .imem_wr_en(d64_wen), .imem_wr_addr(d64_addr),
        .imem_data_in(d64_data), .core_rst(d64_crst),
        .words_loaded(d64_wl), .load_done(d64_done), .load_err(d64_err)
    );

    imem_boot_loader #(.DATA_W(32), .DEPTH(8), .HOLD_CYCLES(HOLD)) u_d8 (
        .clk(clk), .rst(rst), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(d8_ready),
        .imem_wr_en(d8_wen), .imem_wr_addr(d8_addr),
        .imem_data_in(d8_data), .core_rst(d8_crst),
        .words_loaded(d8_wl), .load_done(d8_done), .load_err(d8_err)
    );

    logic        a_rdy[2], a_wen[2], a_crst[2], a_done[2], a_err[2];
    logic [7:0]  a_addr[2], a_wl[2];
    logic [31:0] a_data[2];

    assign a_rdy[0]  = d64_ready;
    assign a_wen[0]  = d64_wen;
    assign a_crst[0] = d64_crst;
    assign a_done[0] = d64_done;
    assign a_err[0]  = d64_err;
    assign a_addr[0] = {2'b0, d64_addr};
    assign a_wl[0]   = {1'b0, d64_wl};
    assign a_data[0] = d64_data;
    assign a_rdy[1]  = d8_ready;
    assign a_wen[1]  = d8_wen;
    assign a_crst[1] = d8_crst;
    assign a_done[1] = d8_done;
    assign a_err[1]  = d8_err;
    assign a_addr[1] = {5'b0, d8_addr};
    assign a_wl[1]   = {4'b0, d8_wl};
    assign a_data[1] = d8_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a load is "in progress", "settling" (hold_left>0),
    // "running" (done) or "overflowed" (err); writes land at word count.
    int          m_dep[2] = '{64, 8};
    bit          m_load[2];
    int          m_hold[2];
    bit          m_done[2];
    bit          m_err[2];
    int          m_wl[2];
    bit          m_wen[2];
    int          m_addr[2];
    logic [31:0] m_data[2];
    bit          m_rstd[2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_rstd[k] = 1'b0;
            m_wen[k]  = 1'b0;
            if (rst) begin
                m_load[k] = 1'b0;
                m_hold[k] = 0;
                m_done[k] = 1'b0;
                m_err[k]  = 1'b0;
                m_wl[k]   = 0;
                m_addr[k] = 0;
                m_data[k] = '0;
                m_rstd[k] = 1'b1;
            end else if (m_load[k]) begin
                if (load_valid) begin
                    m_wen[k]  = 1'b1;
                    m_addr[k] = m_wl[k];
                    m_data[k] = load_data;
                    m_wl[k]   = m_wl[k] + 1;
                    if (load_last) begin
                        m_load[k] = 1'b0;
                        m_hold[k] = HOLD;
                    end else if (m_wl[k] == m_dep[k]) begin
                        m_load[k] = 1'b0;
                        m_err[k]  = 1'b1;
                    end
                end
            end else if (m_hold[k] > 0) begin
                m_hold[k] = m_hold[k] - 1;
                if (m_hold[k] == 0) m_done[k] = 1'b1;
            end else if (load_start) begin
                m_load[k] = 1'b1;
                m_wl[k]   = 0;
                m_done[k] = 1'b0;
                m_err[k]  = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "d64" : "d8";
            chk({p, "_core_rst"}, 32'(a_crst[k]), 32'(!m_done[k]));
            chk({p, "_ready"}, 32'(a_rdy[k]), 32'(m_load[k]));
            chk({p, "_wr_en"}, 32'(a_wen[k]), 32'(m_wen[k]));
            chk({p, "_words"}, 32'(a_wl[k]), 32'(m_wl[k]));
            chk({p, "_done"}, 32'(a_done[k]), 32'(m_done[k]));
            chk({p, "_err"}, 32'(a_err[k]), 32'(m_err[k]));
            if (m_wen[k] || m_rstd[k]) begin
                chk({p, "_addr"}, 32'(a_addr[k]), 32'(m_addr[k]));
                chk({p, "_data"}, a_data[k], m_data[k]);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check_all();
    end

    logic [31:0] prog[4] = '{32'h00500093, 32'h00300113,
                             32'h002081B3, 32'h0000006F};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_crst"}, 32'(d64_crst), 32'd1);
        chk({t, "_rdy"}, 32'(d64_ready), 32'd0);
        chk({t, "_wen"}, 32'(d64_wen), 32'd0);
        chk({t, "_addr"}, 32'(d64_addr), 32'd0);
        chk({t, "_wl"}, 32'(d64_wl), 32'd0);
        chk({t, "_done"}, 32'(d64_done), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        repeat (2) step();
        chk_reset_vals("init");
        rst = 1'b0;
        idle(2);

        start();
        for (int i = 0; i < 4; i++) send(prog[i], i == 3);
        idle(HOLD + 3);
        chk("p1_done", 32'(d64_done), 32'd1);
        chk("p1_wl", 32'(d64_wl), 32'd4);

        start();
        send(prog[0], 1'b0);
        send(prog[1], 1'b0);
        idle(1);
        chk("gap_ready", 32'(d64_ready), 32'd1);
        idle(2);
        send(prog[2], 1'b0);
        send(prog[3], 1'b1);
        idle(HOLD + 3);

        start();
        for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 1'b0);
        chk("ovf_err", 32'(d8_err), 32'd1);
        chk("ovf_rdy", 32'(d8_ready), 32'd0);
        chk("ovf_crst", 32'(d8_crst), 32'd1);
        send(32'hDEAD, 1'b1);
        idle(HOLD + 3);

        start();
        for (int i = 0; i < 8; i++) send(32'h2000 + 32'(i), i == 7);
        idle(HOLD + 3);
        chk("d8_full_done", 32'(d8_done), 32'd1);
        chk("d8_full_wl", 32'(d8_wl), 32'd8);

        start();
        chk("rl_crst", 32'(d64_crst), 32'd1);
        chk("rl_done", 32'(d64_done), 32'd0);
        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        idle(HOLD + 3);

        start();
        send(prog[0], 1'b0);
        send(prog[1], 1'b0);
        pulse_rst();
        chk_reset_vals("rst_load");
        send(32'hBAD0, 1'b0);
        send(32'hBAD1, 1'b1);
        idle(2);
        start();
        for (int i = 0; i < 4; i++) send(prog[i], i == 3);
        idle(2);
        pulse_rst();
        chk_reset_vals("rst_hold");
        idle(2);

        start();
        for (int it = 0; it < 400; it++) begin
            int r;
            r          = $urandom_range(0, 99);
            rst        = (r < 2);
            load_start = (r >= 2 && r < 9);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = $urandom;
            load_last  = ($urandom_range(0, 9) == 0);
            step();
        end
        rst        = 1'b0;
        load_start = 1'b0;
        idle(HOLD + 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
